// File: rtl/seq_det_pkg.sv
// Elaboration-time helpers for the serial pattern detector: builds the KMP
// next-state table from a constant pattern, so no pattern logic exists at run time.
package seq_det_pkg;

  localparam int MAX_PAT_LEN = 16;
  localparam int IDX_W       = $clog2(MAX_PAT_LEN);

  // Bit idx of a vector; idx is trimmed to the vector's index width.
  function automatic logic pbit(input logic [MAX_PAT_LEN-1:0] vec, input int idx);
    return vec[idx[IDX_W-1:0]];
  endfunction

  // Longest proper prefix of the full pattern that is also its suffix.
  // Pattern bit i (i-th bit received) lives at pattern[len-1-i].
  function automatic int seq_fail(input logic [MAX_PAT_LEN-1:0] pattern, input int len);
    int   res;
    logic ok;
    res = 0;
    for (int j = len - 1; j >= 1; j--) begin
      if (res == 0) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++)
          if (pbit(pattern, len - 1 - i) != pbit(pattern, j - 1 - i)) ok = 1'b0;
        if (ok) res = j;
      end
    end
    return res;
  endfunction

  // Next state after accepting bit_in in state 'state'. A full match returns the
  // overlapping restart point; the caller forces 0 for non-overlapping mode.
  function automatic int seq_next(input logic [MAX_PAT_LEN-1:0] pattern, input int len,
                                  input int state, input int bit_in);
    logic [MAX_PAT_LEN-1:0] seen;
    logic                   bv;
    logic                   ok;
    int                     res;
    bv  = (bit_in != 0);
    res = 0;
    if (state >= len) return 0;
    if (bv == pbit(pattern, len - 1 - state)) begin
      if (state < len - 1) return state + 1;
      return seq_fail(pattern, len);
    end
    seen = '0;
    for (int i = 0; i < state; i++) seen[i[IDX_W-1:0]] = pbit(pattern, len - 1 - i);
    seen[state[IDX_W-1:0]] = bv;
    for (int j = state; j >= 1; j--) begin
      if (res == 0) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++)
          if (pbit(pattern, len - 1 - i) != pbit(seen, state + 1 - j + i)) ok = 1'b0;
        if (ok) res = j;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the count at 1 so that event is not lost.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  always_comb begin
    q_d = q_q;
    if (clr)                     q_d = inc ? W'(1) : '0;
    else if (inc && q_q != '1)   q_d = q_q + W'(1);
  end

  assign q = q_q;

endmodule

// File: rtl/seq_detect_param.sv
// Mealy serial-pattern detector with run-time overlap select and a saturating
// match counter; ps is the number of pattern bits matched so far.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 COUNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       x,
  input  logic                       x_valid,
  input  logic                       overlap,
  input  logic                       clear_count,
  output logic                       detect,
  output logic [COUNT_W-1:0]         match_count,
  output logic [$clog2(PAT_LEN)-1:0] ps
);

  localparam int                     PS_W       = $clog2(PAT_LEN);
  localparam int                     NUM_ENC    = 2 ** PS_W;
  localparam logic [MAX_PAT_LEN-1:0] PAT_EXT    = MAX_PAT_LEN'(PATTERN);
  localparam logic [PS_W-1:0]        LAST_STATE = PS_W'(PAT_LEN - 1);
  localparam logic [PS_W-1:0]        FAIL_N     = PS_W'(seq_fail(PAT_EXT, PAT_LEN));
  localparam logic                   LAST_BIT   = PATTERN[0];

  logic [PS_W-1:0] ps_q;
  logic [PS_W-1:0] ps_d;
  logic [PS_W-1:0] next_tbl [NUM_ENC][2];

  // Encodings at or above PAT_LEN are filled with 0 so they recover on the next bit.
  for (genvar s = 0; s < NUM_ENC; s++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int NX = seq_next(PAT_EXT, PAT_LEN, s, b);
      assign next_tbl[s][b] = PS_W'(NX);
    end
  end

  // x is consumed on every cycle x_valid is high; there is no backpressure,
  // and x is a don't-care whenever x_valid is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ps_q <= '0;
    else        ps_q <= ps_d;
  end

  always_comb begin
    ps_d = ps_q;
    if (x_valid) begin
      if (detect) ps_d = overlap ? FAIL_N : '0;
      else        ps_d = next_tbl[ps_q][x];
    end
  end

  always_comb begin
    detect = reset && x_valid && (ps_q == LAST_STATE) && (x == LAST_BIT);
  end

  sat_counter #(
    .W (COUNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (detect),
    .clr   (clear_count),
    .q     (match_count)
  );

  assign ps = ps_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three instances (1011/8-bit count, 1011/2-bit
// count, 111/8-bit count) driven one at a time, checked through a scoreboard.
module tb_seq_detect_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- DUT signals ----------------
  logic       x_a, v_a, ov_a, clr_a, det_a;
  logic [7:0] cnt_a;
  logic [1:0] ps_a;
  logic       x_c, v_c, ov_c, clr_c, det_c;
  logic [1:0] cnt_c;
  logic [1:0] ps_c;
  logic       x_p, v_p, ov_p, clr_p, det_p;
  logic [7:0] cnt_p;
  logic [1:0] ps_p;

  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .COUNT_W(8)) u_a (
    .clk(clk), .reset(reset), .x(x_a), .x_valid(v_a), .overlap(ov_a),
    .clear_count(clr_a), .detect(det_a), .match_count(cnt_a), .ps(ps_a));

  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .COUNT_W(2)) u_c (
    .clk(clk), .reset(reset), .x(x_c), .x_valid(v_c), .overlap(ov_c),
    .clear_count(clr_c), .detect(det_c), .match_count(cnt_c), .ps(ps_c));

  seq_detect_param #(.PAT_LEN(3), .PATTERN(3'b111), .COUNT_W(8)) u_p (
    .clk(clk), .reset(reset), .x(x_p), .x_valid(v_p), .overlap(ov_p),
    .clear_count(clr_p), .detect(det_p), .match_count(cnt_p), .ps(ps_p));

  // ---------------- scoreboard state ----------------
  // entry = {id[1:0], det, ps[1:0], cnt[7:0]}
  logic [12:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int busy  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic sel_det(input logic [1:0] id);
    return (id == 2'd0) ? det_a : (id == 2'd1) ? det_c : det_p;
  endfunction

  function automatic logic [1:0] sel_ps(input logic [1:0] id);
    return (id == 2'd0) ? ps_a : (id == 2'd1) ? ps_c : ps_p;
  endfunction

  function automatic logic [7:0] sel_cnt(input logic [1:0] id);
    return (id == 2'd0) ? cnt_a : (id == 2'd1) ? {6'd0, cnt_c} : cnt_p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    v_a = 1'b0; clr_a = 1'b0;
    v_c = 1'b0; clr_c = 1'b0;
    v_p = 1'b0; clr_p = 1'b0;
  endtask

  // One cycle of stimulus to DUT id; expected detect this cycle, ps/count after the edge.
  task automatic step(input int id, input logic xb, input logic vb, input logic ovb,
                      input logic clrb, input logic edet, input logic [1:0] eps,
                      input logic [7:0] ecnt);
    logic [1:0] id2;
    id2 = id[1:0];
    @(posedge clk); #1;
    idle_inputs();
    case (id2)
      2'd0:    begin x_a = xb; v_a = vb; ov_a = ovb; clr_a = clrb; end
      2'd1:    begin x_c = xb; v_c = vb; ov_c = ovb; clr_c = clrb; end
      default: begin x_p = xb; v_p = vb; ov_p = ovb; clr_p = clrb; end
    endcase
    exp_q.push_back({id2, edet, eps, ecnt});
  endtask

  task automatic drain();
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("drain", exp_q.size() + busy, 0);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        busy = 1;
        e = exp_q.pop_front();
        chk($sformatf("detect[id%0d]", e[12:11]), sel_det(e[12:11]), e[10]);
        @(posedge clk); #1;
        chk($sformatf("ps[id%0d]", e[12:11]), sel_ps(e[12:11]), e[9:8]);
        chk($sformatf("count[id%0d]", e[12:11]), sel_cnt(e[12:11]), e[7:0]);
        busy = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [6:0] sbits;
    logic [1:0] g_ps  [7];
    logic       g_det [7];
    logic [7:0] g_cnt;
    logic [7:0] c_cnt;

    reset = 1'b0;
    x_a = 1'b0; x_c = 1'b0; x_p = 1'b0;
    ov_a = 1'b0; ov_c = 1'b0; ov_p = 1'b0;
    idle_inputs();

    // Reset held with valid bits toggling: everything stays at 0.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      x_a = i[0]; x_c = ~i[0]; x_p = 1'b1;
      v_a = 1'b1; v_c = 1'b1; v_p = 1'b1;
      @(negedge clk);
      chk("rst_ps_a", ps_a, 0);   chk("rst_det_a", det_a, 0); chk("rst_cnt_a", cnt_a, 0);
      chk("rst_ps_c", ps_c, 0);   chk("rst_det_c", det_c, 0); chk("rst_cnt_c", cnt_c, 0);
      chk("rst_ps_p", ps_p, 0);   chk("rst_det_p", det_p, 0); chk("rst_cnt_p", cnt_p, 0);
    end
    @(posedge clk); #1;
    idle_inputs();
    #2 reset = 1'b1;

    // Overlapping: 1,0,1,1,0,1,1 -> detects on bits 4 and 7.
    step(0, 1, 1, 1, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0, 0, 2, 0);
    step(0, 1, 1, 1, 0, 0, 3, 0);
    step(0, 1, 1, 1, 0, 1, 1, 1);
    step(0, 0, 1, 1, 0, 0, 2, 1);
    step(0, 1, 1, 1, 0, 0, 3, 1);
    step(0, 1, 1, 1, 0, 1, 1, 2);
    step(0, 0, 1, 1, 0, 0, 2, 2);
    step(0, 0, 1, 1, 0, 0, 0, 2);

    // Non-overlapping: same stream -> detect on bit 4 only, ps 0,1,1 afterwards.
    step(0, 1, 1, 0, 0, 0, 1, 2);
    step(0, 0, 1, 0, 0, 0, 2, 2);
    step(0, 1, 1, 0, 0, 0, 3, 2);
    step(0, 1, 1, 0, 0, 1, 0, 3);
    step(0, 0, 1, 0, 0, 0, 0, 3);
    step(0, 1, 1, 0, 0, 0, 1, 3);
    step(0, 1, 1, 0, 0, 0, 1, 3);

    // KMP fallback: "101"+0 keeps "10" -> ps 2.
    step(0, 0, 1, 0, 0, 0, 2, 3);
    step(0, 1, 1, 0, 0, 0, 3, 3);
    step(0, 0, 1, 0, 0, 0, 2, 3);
    step(0, 1, 1, 0, 0, 0, 3, 3);
    step(0, 1, 1, 0, 0, 1, 0, 4);

    // Overlap toggled mid-pattern; only its value on the match cycle matters.
    step(0, 1, 1, 0, 0, 0, 1, 4);
    step(0, 0, 1, 1, 0, 0, 2, 4);
    step(0, 1, 1, 0, 0, 0, 3, 4);
    step(0, 1, 1, 1, 0, 1, 1, 5);
    step(0, 0, 1, 1, 0, 0, 2, 5);
    step(0, 0, 1, 1, 0, 0, 0, 5);

    // Gaps: overlapping stream with invalid cycles (random x) interleaved.
    sbits = 7'b1011011;
    g_ps  = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
    g_det = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    g_cnt = 8'd5;
    for (int i = 0; i < 7; i++) begin
      if (g_det[i]) g_cnt = g_cnt + 8'd1;
      step(0, sbits[6-i], 1, 1, 0, g_det[i], g_ps[i], g_cnt);
      if (i != 5) begin
        for (int g = 0; g < int'($urandom_range(1, 2)); g++)
          step(0, 1'($urandom_range(0, 1)), 0, 1, 0, 0, g_ps[i], g_cnt);
      end
    end

    // Clear alone, clear with a detect, clear on an idle cycle.
    step(0, 0, 1, 1, 1, 0, 2, 0);
    step(0, 1, 1, 1, 0, 0, 3, 0);
    step(0, 1, 1, 1, 1, 1, 1, 1);
    step(0, 1, 0, 1, 1, 0, 1, 0);
    step(0, 0, 1, 1, 0, 0, 2, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0);
    drain();

    // 2-bit counter saturates at 3 after five matches.
    step(1, 1, 1, 1, 0, 0, 1, 0);
    c_cnt = 8'd0;
    for (int k = 1; k <= 5; k++) begin
      step(1, 0, 1, 1, 0, 0, 2, c_cnt);
      step(1, 1, 1, 1, 0, 0, 3, c_cnt);
      c_cnt = (k > 3) ? 8'd3 : 8'(k);
      step(1, 1, 1, 1, 0, 1, 1, c_cnt);
    end
    drain();

    // Self-overlapping 111: detects on bits 3, 4, 5; then non-overlapping restart.
    step(2, 1, 1, 1, 0, 0, 1, 0);
    step(2, 1, 1, 1, 0, 0, 2, 0);
    step(2, 1, 1, 1, 0, 1, 2, 1);
    step(2, 1, 1, 1, 0, 1, 2, 2);
    step(2, 1, 1, 1, 0, 1, 2, 3);
    step(2, 0, 1, 1, 0, 0, 0, 3);
    step(2, 1, 1, 0, 0, 0, 1, 3);
    step(2, 1, 1, 0, 0, 0, 2, 3);
    step(2, 1, 1, 0, 0, 1, 0, 4);
    drain();

    // Mid-pattern reset: after 1,0,1 a reset pulse between edges clears ps at once.
    step(0, 1, 1, 1, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0, 0, 2, 0);
    step(0, 1, 1, 1, 0, 0, 3, 0);
    drain();
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("midrst_ps", ps_a, 0);
    chk("midrst_det", det_a, 0);
    chk("midrst_cnt", cnt_a, 0);
    #1 reset = 1'b1;
    step(0, 1, 1, 1, 0, 0, 1, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
